// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Word-addressed data-memory responder for the CPU load/store port. It
//   accepts one request at a time on a valid/ready request channel, waits
//   WAIT_CYCLES wait states, performs the access against 2^ADDR_WIDTH 32-bit
//   words of storage, and returns a registered response on a valid/ready
//   response channel. Misaligned or out-of-range accesses return rsp_err=1
//   and leave storage untouched.
//
// Parameters
//   ADDR_WIDTH  : word-address bits (storage depth = 2^ADDR_WIDTH words)
//   WAIT_CYCLES : wait states between accept and access commit (0..15)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder idle and out of reset
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_be     in   byte enables, bit i covers wdata[8i+7:8i]
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts response
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  access was misaligned or out of range
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;

    // Request fields captured at accept, used when the access commits later.
    logic                    write_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;

    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [31:0]             mem [DEPTH];

    logic                    accept;
    logic                    do_access;
    logic                    acc_write;
    logic [31:0]             acc_addr;
    logic [31:0]             acc_wdata;
    logic [3:0]              acc_be;
    logic                    acc_err;
    logic [ADDR_WIDTH-1:0]   acc_idx;

    assign req_ready = (state_q == S_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    // With zero wait states the access commits on the accept edge itself, so
    // the live request fields are used in IDLE; otherwise the captured ones.
    assign acc_write = (state_q == S_IDLE) ? req_write : write_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == S_IDLE) ? req_be    : be_q;

    assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                       ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign acc_idx   = acc_addr[ADDR_WIDTH+1:2];

    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        do_access   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_WAIT;
                    end else begin
                        do_access = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Commit: the response is fixed here and held until the handshake.
        if (do_access) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            err_d       = acc_err;
            rdata_d     = (!acc_err && !acc_write) ? mem[acc_idx] : 32'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // NOTE: storage has no reset; contents survive rst_n and only committed
    // stores change them. A store still in WAIT never reaches do_access.
    always_ff @(posedge clk) begin
        if (do_access && acc_write && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Two responders: unit 0 with WAIT_CYCLES=2, unit 1 with WAIT_CYCLES=0, both
//   ADDR_WIDTH=10. Directed scenarios plus random loads/stores are compared
//   against a word-array reference model of the storage.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_be;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference storage: 1024 words per unit (byte address < 0x1000).
    logic [31:0] mdl [2][1024];

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_write (req_write[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_be    (req_be[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_write (req_write[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_be    (req_be[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        failed++;
        $display("FAIL %s: timed out waiting on DUT", tag);
    endtask

    // One complete transaction on unit u. hold = cycles rsp_ready is kept low
    // once the response is visible (0 = rsp_ready already high beforehand).
    task automatic txn(input int u, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input int hold,
                       output logic [31:0] got);
        bit          e;
        logic [31:0] exp_rdata;
        int          wc;
        int          n;

        e         = (a[1:0] != 2'b00) || (a >= 32'h1000);
        exp_rdata = (!e && !w) ? mdl[u][a[11:2]] : 32'd0;
        got       = 32'hx;

        @(negedge clk);
        req_valid[u] = 1'b1;
        req_write[u] = w;
        req_addr[u]  = a;
        req_wdata[u] = d;
        req_be[u]    = be;
        rsp_ready[u] = (hold == 0);

        wc = 0;
        while (!req_ready[u] && wc < 20) begin
            @(negedge clk);
            wc++;
        end
        if (wc >= 20) begin
            timeout("accept");
            req_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);                      // accept edge
        if (w && !e) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl[u][a[11:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
        @(negedge clk);
        req_valid[u] = 1'b0;
        req_addr[u]  = $urandom;             // must be ignored after accept
        req_wdata[u] = $urandom;
        n = 1;
        if (wait_of(u) > 0) check("busy_ready", 32'(req_ready[u]), 32'd0);
        while (!rsp_valid[u] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            timeout("rsp_valid");
            return;
        end
        check("latency", 32'(n), 32'(wait_of(u) + 1));
        check("rsp_err", 32'(rsp_err[u]), 32'(e));
        check("rsp_rdata", rsp_rdata[u], exp_rdata);
        got = rsp_rdata[u];

        for (int i = 0; i < hold; i++) begin
            if (i > 0) begin
                check("hold_valid", 32'(rsp_valid[u]), 32'd1);
                check("hold_rdata", rsp_rdata[u], exp_rdata);
                check("hold_err", 32'(rsp_err[u]), 32'(e));
            end
            check("hold_ready", 32'(req_ready[u]), 32'd0);
            @(negedge clk);
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);                      // one edge after the handshake
        check("post_valid", 32'(rsp_valid[u]), 32'd0);
        check("post_ready", 32'(req_ready[u]), 32'd1);
        rsp_ready[u] = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int          r;

        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = '0;

        // Reset state
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_valid", 32'(rsp_valid[u]), 32'd0);
            check("rst_rdata", rsp_rdata[u], 32'd0);
            check("rst_err", 32'(rsp_err[u]), 32'd0);
            check("rst_ready", 32'(req_ready[u]), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) check("rel_ready", 32'(req_ready[u]), 32'd1);

        // Fill words 0..15 and 0x3FC of both units with known data.
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 16; i++) txn(u, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, got);
            txn(u, 1'b1, 32'h3FC, $urandom, 4'hF, 0, got);
        end

        // Store then load, byte enables (unit 0, 2 wait states)
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, got);
        check("st_rdata_zero", got, 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, 0, got);
        check("ld_deadbeef", got, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, got);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 0, got);
        check("ld_be_merge", got, 32'hDE22BE44);

        // Response backpressure, then an immediate next request
        txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 5, got);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 0, got);

        // be=0000 store is a no-op with a response
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, got);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 0, got);
        check("be0_noop", got, 32'hDE22BE44);

        // Error accesses
        txn(0, 1'b1, 32'h12, 32'h55555555, 4'b1111, 0, got);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, 0, got);
        check("err_untouched", got, 32'hDE22BE44);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'b1111, 0, got);

        // Reset while a store of 0xCAFEF00D to 0x20 sits in WAIT
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hCAFEF00D;
        req_be[0]    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstw_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstw_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstw_rel_ready", 32'(req_ready[0]), 32'd1);
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, got);   // model keeps prior word

        // Zero wait states (unit 1)
        txn(1, 1'b1, 32'h3FC, 32'hA5C3_0F96, 4'hF, 0, got);
        txn(1, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, got);
        check("w0_ld_3fc", got, 32'hA5C3_0F96);
        txn(1, 1'b0, 32'h3FE, 32'h0, 4'hF, 2, got);

        // Random mix against the model
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 40; k++) begin
                r = $urandom_range(0, 9);
                if (r <= 6)      a = 32'($urandom_range(0, 15) * 4);
                else if (r == 7) a = 32'h3FC;
                else if (r == 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                else             a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
                txn(u, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), got);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
